// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg
// Shared types for the ap_ctrl driver: the controller state encoding, the
// error code reported on err_code, and the default counter width.
package ap_ctrl_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_code_t;

endpackage

// File: rtl/ap_ctrl_watchdog.sv
// ap_ctrl_watchdog
// Counts consecutive enabled cycles in which no handshake event occurred.
// expired is raised during the TIMEOUT-th such cycle, so the owner can
// leave its active state on that same clock edge.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high reset
//   enable  count only while high (controller is in RUN or DRAIN)
//   kick    a handshake event this cycle; restarts the idle count
//   expired TIMEOUT idle cycles have elapsed
module ap_ctrl_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] idle_cnt;

    // Idle counter; it stops at LAST so it can never wrap back to zero
    // while the controller is still deciding to leave.
    always_ff @(posedge clock) begin
        if (reset || !enable || kick) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + WD_W'(1);
        end
    end

    assign expired = enable && !kick && (idle_cnt == LAST);

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver
// Drives a block-level ap_ctrl handshake for a requested number of
// transactions, counts accepted starts and retired dones, measures the run
// length and flags timeouts and spurious dones.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   go                    level-sampled request to begin a run
//   num_trans             transaction count, latched when a run is accepted
//   cont_hold             holds ap_continue low (backpressure)
//   ap_ready, ap_done     handshake inputs from the driven block
//   ap_start, ap_continue handshake outputs to the driven block
//   finish, err, err_code run complete / aborted, error flag and reason
//   issued_cnt, done_cnt, cycle_cnt  starts, dones, run length in cycles
module ap_ctrl_driver
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] num_trans,
    input  logic             cont_hold,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_start,
    output logic             ap_continue,
    output logic             finish,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_next;
    err_code_t        err_q, code_next;
    logic [CNT_W-1:0] target, target_next;
    logic [CNT_W-1:0] issued_next, done_next, cycle_next;
    logic             start_next, cont_next, finish_next, err_next;
    logic             start_acc, done_ret, active, wd_expired;

    assign start_acc = ap_start && ap_ready;
    assign done_ret  = ap_done && ap_continue;
    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign err_code  = err_q;

    ap_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .enable  (active),
        .kick    (start_acc || done_ret),
        .expired (wd_expired)
    );

    // Next-state and next-counter logic. A done retired while every issued
    // start has already been matched (counts from before this cycle) is a
    // protocol violation and takes priority over normal counting.
    always_comb begin
        state_next  = state;
        target_next = target;
        issued_next = issued_cnt;
        done_next   = done_cnt;
        cycle_next  = cycle_cnt;
        code_next   = err_q;
        case (state)
            ST_IDLE, ST_FINISH: begin
                if (go) begin
                    issued_next = '0;
                    done_next   = '0;
                    cycle_next  = '0;
                    code_next   = ERR_NONE;
                    if (num_trans != '0) begin
                        target_next = num_trans;
                        state_next  = ST_RUN;
                    end else begin
                        state_next  = ST_FINISH;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (cycle_cnt != '1) begin
                    cycle_next = cycle_cnt + ONE;
                end
                if (done_ret && (done_cnt == issued_cnt)) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_SPURIOUS;
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_TIMEOUT;
                end else begin
                    if (start_acc) begin
                        issued_next = issued_cnt + ONE;
                    end
                    if (done_ret) begin
                        done_next = done_cnt + ONE;
                    end
                    if ((state == ST_RUN) && start_acc &&
                        ((issued_cnt + ONE) == target)) begin
                        state_next = ST_DRAIN;
                    end
                    if ((state == ST_DRAIN) && done_ret &&
                        ((done_cnt + ONE) == target)) begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_comb begin
        start_next  = (state_next == ST_RUN);
        cont_next   = ((state_next == ST_RUN) || (state_next == ST_DRAIN)) && !cont_hold;
        finish_next = (state_next == ST_FINISH) || (state_next == ST_ERROR);
        err_next    = (state_next == ST_ERROR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            target      <= '0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            cycle_cnt   <= '0;
            err_q       <= ERR_NONE;
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            finish      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            target      <= target_next;
            issued_cnt  <= issued_next;
            done_cnt    <= done_next;
            cycle_cnt   <= cycle_next;
            err_q       <= code_next;
            ap_start    <= start_next;
            ap_continue <= cont_next;
            finish      <= finish_next;
            err         <= err_next;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver
// Self-checking bench for ap_ctrl_driver. A small responder plays the driven
// block (ap_ready in the same cycle as ap_start, ap_done two cycles after each
// accepted start, held until retired). Each run pushes its expected result
// to a scoreboard queue; the entry is popped and compared when finish rises.
module tb_ap_ctrl_driver;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             go;
    logic [CNT_W-1:0] num_trans;
    logic             cont_hold;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_start;
    logic             ap_continue;
    logic             finish;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    logic ready_en;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        int latency;
        int issued;
        int done;
        int cycles;
        int err;
        int code;
        int saw_start;
    } exp_t;

    exp_t sb[$];

    int done_timers[$];
    int ready_dones = 0;
    bit snap_accept = 1'b0;
    bit snap_retire = 1'b0;
    bit spurious_req = 1'b0;

    ap_ctrl_driver #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .num_trans   (num_trans),
        .cont_hold   (cont_hold),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .finish      (finish),
        .err         (err),
        .err_code    (err_code),
        .issued_cnt  (issued_cnt),
        .done_cnt    (done_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clock = ~clock;

    assign ap_ready = ready_en & ap_start;

    // Responder: updates on the falling edge using what the previous rising
    // edge saw, then records what the coming rising edge will see.
    always @(negedge clock) begin
        int n;
        int t;
        if (snap_retire && ready_dones > 0) ready_dones--;
        n = done_timers.size();
        for (int i = 0; i < n; i++) begin
            t = done_timers.pop_front() - 1;
            if (t <= 0) ready_dones++;
            else done_timers.push_back(t);
        end
        if (snap_accept) done_timers.push_back(1);
        ap_done = (ready_dones > 0) || spurious_req;
        spurious_req = 1'b0;
        snap_accept = ap_start && ready_en;
        snap_retire = ap_done && ap_continue;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic flushResponder();
        done_timers.delete();
        ready_dones = 0;
        snap_accept = 1'b0;
        snap_retire = 1'b0;
        spurious_req = 1'b0;
        ap_done = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_ap_start"}, 64'(ap_start), 0);
        checkOutput({tag, "_ap_continue"}, 64'(ap_continue), 0);
        checkOutput({tag, "_finish"}, 64'(finish), 0);
        checkOutput({tag, "_err"}, 64'(err), 0);
        checkOutput({tag, "_err_code"}, 64'(err_code), 0);
        checkOutput({tag, "_issued"}, 64'(issued_cnt), 0);
        checkOutput({tag, "_done"}, 64'(done_cnt), 0);
        checkOutput({tag, "_cycles"}, 64'(cycle_cnt), 0);
    endtask

    // One reset cycle; optionally with go raised to show it is ignored.
    task automatic applyReset(input string tag, input bit go_during);
        @(negedge clock);
        reset = 1'b1;
        go = go_during;
        num_trans = CNT_W'(1);
        @(posedge clock);
        #1 flushResponder();
        @(negedge clock);
        checkZero(tag);
        reset = 1'b0;
        go = 1'b0;
        cont_hold = 1'b0;
    endtask

    // Launch one run, push its expectation, wait (bounded) for finish and
    // compare against the popped scoreboard entry.
    task automatic applyStimulus(input string tag, input int n, input bit rdy,
                                 input int hold, input bit spurious,
                                 input int e_lat, input int e_iss, input int e_done,
                                 input int e_cyc, input int e_err, input int e_code,
                                 input int e_saw);
        exp_t e;
        exp_t x;
        int   waited;
        bit   seen;
        bit   saw;
        e.latency = e_lat; e.issued = e_iss; e.done = e_done; e.cycles = e_cyc;
        e.err = e_err; e.code = e_code; e.saw_start = e_saw;
        @(negedge clock);
        ready_en = rdy;
        cont_hold = (hold > 0);
        num_trans = CNT_W'(n);
        go = 1'b1;
        sb.push_back(e);
        @(posedge clock);
        #1 if (spurious) spurious_req = 1'b1;
        waited = 0;
        seen = 1'b0;
        saw = 1'b0;
        while (!seen && waited < 300) begin
            @(negedge clock);
            waited++;
            go = 1'b0;
            if (ap_start) saw = 1'b1;
            if (hold > 0 && waited <= hold) begin
                checkOutput({tag, "_done_during_hold"}, 64'(done_cnt), 0);
                if (waited == hold) cont_hold = 1'b0;
            end
            if (finish) seen = 1'b1;
        end
        x = sb.pop_front();
        if (!seen) begin
            checkOutput({tag, "_finish_seen"}, 0, 1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(waited), 64'(x.latency));
            checkOutput({tag, "_issued"}, 64'(issued_cnt), 64'(x.issued));
            if (x.done >= 0) checkOutput({tag, "_done"}, 64'(done_cnt), 64'(x.done));
            if (x.cycles >= 0) checkOutput({tag, "_cycles"}, 64'(cycle_cnt), 64'(x.cycles));
            checkOutput({tag, "_err"}, 64'(err), 64'(x.err));
            checkOutput({tag, "_err_code"}, 64'(err_code), 64'(x.code));
            checkOutput({tag, "_start_seen"}, 64'(saw), 64'(x.saw_start));
            checkOutput({tag, "_ap_start_low"}, 64'(ap_start), 0);
            checkOutput({tag, "_ap_continue_low"}, 64'(ap_continue), 0);
        end
    endtask

    initial begin
        bit seen_start;
        reset = 1'b1;
        go = 1'b0;
        num_trans = '0;
        cont_hold = 1'b0;
        ready_en = 1'b0;
        ap_done = 1'b0;

        applyReset("por", 1'b0);

        //            tag           n  rdy hold spur lat iss done cyc err code saw
        applyStimulus("zero",       0, 1,  0,   0,   1,  0,  0,   0,  0,  0,   0);
        applyStimulus("b2b",        3, 1,  0,   0,   6,  3,  3,   5,  0,  0,   1);
        applyStimulus("backpress",  2, 1,  10,  0,   13, 2,  2,   12, 0,  0,   1);
        applyStimulus("spurious",   2, 0,  0,   1,   2,  0,  -1,  1,  1,  2,   1);

        applyReset("rst_after_err", 1'b0);
        applyStimulus("timeout",    5, 0,  0,   0,   17, 0,  0,   16, 1,  1,   1);

        // The error state ignores go.
        @(negedge clock);
        ready_en = 1'b1;
        num_trans = CNT_W'(1);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        @(negedge clock);
        checkOutput("err_sticky_err", 64'(err), 1);
        checkOutput("err_sticky_ap_start", 64'(ap_start), 0);
        checkOutput("err_sticky_issued", 64'(issued_cnt), 0);

        // Reset landing in DRAIN of a 4-transaction run.
        applyReset("rst_before_mid", 1'b0);
        @(negedge clock);
        ready_en = 1'b1;
        cont_hold = 1'b1;
        num_trans = CNT_W'(4);
        go = 1'b1;
        seen_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            go = 1'b0;
            if (ap_start) seen_start = 1'b1;
            if (seen_start && !ap_start) break;
        end
        checkOutput("mid_drain_issued", 64'(issued_cnt), 4);
        checkOutput("mid_drain_finish", 64'(finish), 0);
        applyReset("mid_reset", 1'b1);
        applyStimulus("after_reset", 1, 1, 0,   0,   4,  1,  1,   3,  0,  0,   1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
